hazard_encoder: RTL and testbench
=================================

# hazard_encoder

Registered encoder that converts a list of up to 15 rectangular hazard regions on the 8-row × 32-column sensor/neuron grid into a coarse 32-zone occupancy map. The map is split across two 16-bit vectors. `vec1` covers grid rows 0–3 and `vec2` covers rows 4–7. It sits between the hazard detection front end and the neuromorphic core input stage, which consumes the zone bits as spike-input lines.

## Interface
Parameters:
- `NUM_SLOTS`, 16: hazard table depth; fixed by the 4-bit count.
- `COORD_W`, 8: coordinate width.

Ports:
- `clk`  in  1: single clock; all state on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `num_hazards`  in  4: number of valid table entries (0–15). Entries `0 .. num_hazards-1` are used.
- `top[0:15]`  in  16×8: inclusive top row per hazard (unpacked array).
- `left[0:15]`  in  16×8: inclusive left column per hazard.
- `bottom[0:15]`  in  16×8: inclusive bottom row per hazard.
- `right[0:15]`  in  16×8: inclusive right column per hazard.
- `vec1`  out  16: zone map for zone-rows 0–1 (grid rows 0–3), registered.
- `vec2`  out  16: zone map for zone-rows 2–3 (grid rows 4–7), registered.

## Operation
- Grid: rows 0–7, columns 0–31. Zone size is 2 rows × 4 columns. Zone coordinates are `zr = row>>1` (0–3) and `zc = col>>2` (0–7).
- Bit mapping:
  - Zone (zr, zc) with zr<2 drives `vec1[zr*8+zc]`.
  - Zone (zr, zc) with zr≥2 drives `vec2[(zr-2)*8+zc]`.
- A zone bit is 1 when any valid hazard rectangle overlaps at least one cell of that zone.
- Hazard i is valid when `i < num_hazards`. Entries at or above `num_hazards` are ignored regardless of their contents. Entry 15 is never valid.
- Per hazard:
  - Empty rectangle (`top>bottom` or `left>right`): contributes nothing.
  - Clip: `bottom` is clamped to 7 and `right` to 31.
  - Hazard with `top>7` or `left>31`: contributes nothing.
- Zone range after clipping is rows `top>>1 .. bottom>>1` and columns `left>>2 .. right>>2`. All zones in that range are set.
- Outputs are the bitwise OR over all valid hazards. The result is order-independent, and duplicate or overlapping hazards are harmless.
- `num_hazards = 0`: both vectors are 0.

## Timing
- Fully combinational evaluation of the sampled inputs. The result is registered into `vec1`/`vec2` on the next rising edge, giving 1-cycle latency.
- Inputs are sampled every cycle. There is no handshake and no valid/ready. Outputs track inputs continuously with 1-cycle delay.
- Reset: when `rst`=1 at a rising edge, `vec1`=0 and `vec2`=0. Reset wins over new data in the same cycle.
- The first post-reset result appears on the edge after `rst` deasserts.
- Asserting `rst` mid-stream clears the outputs on that edge. No other state exists.
- Changing `num_hazards` or table contents between edges only affects the next registered value. No glitches propagate to the outputs.

## Structure
- Shared package `hazard_pkg` holds:
  - Constants `GRID_ROWS=8`, `GRID_COLS=32`, `ZONE_H=2`, `ZONE_W=4`, `ZONE_ROWS=4`, `ZONE_COLS=8`, `MAX_HAZARDS=16`.
  - Typedef `coord_t` (8-bit).
- Sub-module `hazard_zone_mask`: combinational. Takes one rectangle plus a valid flag and produces a 32-bit zone mask (bit `zr*8+zc`), applying the clip and empty rules.
- Top level instantiates 16 masks with `valid = (i < num_hazards)` and ORs them. It registers bits [15:0] into `vec1` and bits [31:16] into `vec2`.

## Test plan
- Two hazards: `num_hazards=2`; (0,0,1,2) and (6,20,7,25); rest 0. After one edge, `vec1=16'h0001` and `vec2=16'h6000`.
- Count masking: same table with `num_hazards=1` gives `vec1=16'h0001`, `vec2=16'h0000`. With `num_hazards=0`, both vectors are 0 even though entries hold nonzero data.
- Full grid and clipping: `num_hazards=1`, (0,0,200,255) gives `vec1=16'hFFFF`, `vec2=16'hFFFF`.
- Boundary straddle and empty rectangle:
  - `num_hazards=2`, (3,3,4,4) and (5,0,2,9). The second entry is empty.
  - Result: rows 3–4 map to zr 1–2 and cols 3–4 map to zc 0–1, so `vec1=16'h0300` and `vec2=16'h0003`.
- Out-of-range start: `num_hazards=1`, (8,0,9,3) gives both vectors 0.
- Reset: drive the full-grid case, then assert `rst` for one edge. Both outputs are 0 on that edge. After deassert, the outputs return to `16'hFFFF` one edge later. With `rst` held high, the outputs stay 0 despite changing inputs.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared grid geometry and coordinate type for the hazard zone encoder.
package hazard_pkg;

   localparam int GRID_ROWS   = 8;
   localparam int GRID_COLS   = 32;
   localparam int ZONE_H      = 2;
   localparam int ZONE_W      = 4;
   localparam int ZONE_ROWS   = 4;
   localparam int ZONE_COLS   = 8;
   localparam int MAX_HAZARDS = 16;

   typedef logic [7:0] coord_t;

   localparam coord_t MAX_ROW = coord_t'(GRID_ROWS - 1);
   localparam coord_t MAX_COL = coord_t'(GRID_COLS - 1);

endpackage

// File: rtl/hazard_zone_mask.sv
// Converts one inclusive hazard rectangle into a 32-bit zone occupancy mask.
module hazard_zone_mask
   import hazard_pkg::*;
(
   input  logic                           valid,
   input  coord_t                         top,
   input  coord_t                         left,
   input  coord_t                         bottom,
   input  coord_t                         right,
   output logic [ZONE_ROWS*ZONE_COLS-1:0] mask
);

   coord_t      bottom_c;
   coord_t      right_c;
   logic        active;
   logic [31:0] zr_lo;
   logic [31:0] zr_hi;
   logic [31:0] zc_lo;
   logic [31:0] zc_hi;

   // Emptiness is judged on the raw corners; only the far edges get clipped.
   assign active   = valid && (top <= bottom) && (left <= right) &&
                     (top <= MAX_ROW) && (left <= MAX_COL);
   assign bottom_c = (bottom > MAX_ROW) ? MAX_ROW : bottom;
   assign right_c  = (right  > MAX_COL) ? MAX_COL : right;

   assign zr_lo = 32'(top)      >> 1;
   assign zr_hi = 32'(bottom_c) >> 1;
   assign zc_lo = 32'(left)     >> 2;
   assign zc_hi = 32'(right_c)  >> 2;

   for (genvar r = 0; r < ZONE_ROWS; r++) begin : g_row
      for (genvar c = 0; c < ZONE_COLS; c++) begin : g_col
         assign mask[r*ZONE_COLS + c] = active &&
                                        (32'(r) >= zr_lo) && (32'(r) <= zr_hi) &&
                                        (32'(c) >= zc_lo) && (32'(c) <= zc_hi);
      end
   end

endmodule

// File: rtl/hazard_encoder.sv
// Registered encoder: ORs the zone masks of all valid hazard slots into a
// 32-zone map, split into vec1 (grid rows 0-3) and vec2 (grid rows 4-7).
module hazard_encoder
   import hazard_pkg::*;
#(
   parameter int NUM_SLOTS = 16,
   parameter int COORD_W   = 8
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         num_hazards,
   input  logic [COORD_W-1:0] top    [0:NUM_SLOTS-1],
   input  logic [COORD_W-1:0] left   [0:NUM_SLOTS-1],
   input  logic [COORD_W-1:0] bottom [0:NUM_SLOTS-1],
   input  logic [COORD_W-1:0] right  [0:NUM_SLOTS-1],
   output logic [15:0]        vec1,
   output logic [15:0]        vec2
);

   logic [ZONE_ROWS*ZONE_COLS-1:0] slot_mask [NUM_SLOTS];
   logic [ZONE_ROWS*ZONE_COLS-1:0] zone_map;

   // Slot 15 can never satisfy i < num_hazards, so it is always ignored.
   for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
      hazard_zone_mask u_mask (
         .valid  (4'(i) < num_hazards),
         .top    (top[i]),
         .left   (left[i]),
         .bottom (bottom[i]),
         .right  (right[i]),
         .mask   (slot_mask[i])
      );
   end

   always_comb begin
      zone_map = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         zone_map = zone_map | slot_mask[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vec1 <= '0;
         vec2 <= '0;
      end else begin
         vec1 <= zone_map[15:0];
         vec2 <= zone_map[31:16];
      end
   end

endmodule

// File: tb/tb_hazard_encoder.sv
// Directed table-driven bench for hazard_encoder plus reset and slot-15 sequences.
module tb_hazard_encoder;
   import hazard_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  num_hazards;
   coord_t      top    [0:15];
   coord_t      left   [0:15];
   coord_t      bottom [0:15];
   coord_t      right  [0:15];
   logic [15:0] vec1;
   logic [15:0] vec2;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [3:0]  n;
      coord_t      rect [4][4];
      logic [15:0] e1;
      logic [15:0] e2;
   } vec_t;

   localparam int NUM_VECS = 11;
   vec_t vecs [NUM_VECS];

   hazard_encoder dut (
      .clk         (clk),
      .rst         (rst),
      .num_hazards (num_hazards),
      .top         (top),
      .left        (left),
      .bottom      (bottom),
      .right       (right),
      .vec1        (vec1),
      .vec2        (vec2)
   );

   always #5 clk = ~clk;

   task automatic set_vec(input int idx, input string name, input int n,
                          input logic [15:0] e1, input logic [15:0] e2);
      vecs[idx].name = name;
      vecs[idx].n    = 4'(n);
      vecs[idx].e1   = e1;
      vecs[idx].e2   = e2;
      for (int k = 0; k < 4; k++)
         for (int j = 0; j < 4; j++)
            vecs[idx].rect[k][j] = '0;
   endtask

   task automatic set_rect(input int idx, input int k,
                           input int t, input int l, input int b, input int r);
      vecs[idx].rect[k][0] = 8'(t);
      vecs[idx].rect[k][1] = 8'(l);
      vecs[idx].rect[k][2] = 8'(b);
      vecs[idx].rect[k][3] = 8'(r);
   endtask

   task automatic fill_table(input int t, input int l, input int b, input int r);
      for (int i = 0; i < 16; i++) begin
         top[i] = 8'(t); left[i] = 8'(l); bottom[i] = 8'(b); right[i] = 8'(r);
      end
   endtask

   task automatic apply_stimulus(input int idx);
      fill_table(0, 0, 0, 0);
      num_hazards = vecs[idx].n;
      for (int k = 0; k < 4; k++) begin
         top[k]    = vecs[idx].rect[k][0];
         left[k]   = vecs[idx].rect[k][1];
         bottom[k] = vecs[idx].rect[k][2];
         right[k]  = vecs[idx].rect[k][3];
      end
   endtask

   task automatic check_output(input string name, input logic [15:0] e1,
                               input logic [15:0] e2);
      checks++;
      if (vec1 !== e1) begin
         errors++;
         $display("[TB] FAIL %s vec1: got %h expected %h", name, vec1, e1);
      end
      checks++;
      if (vec2 !== e2) begin
         errors++;
         $display("[TB] FAIL %s vec2: got %h expected %h", name, vec2, e2);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      set_vec(0, "two_hazards", 2, 16'h0001, 16'h6000);
      set_rect(0, 0, 0, 0, 1, 2);
      set_rect(0, 1, 6, 20, 7, 25);
      set_vec(1, "count_one", 1, 16'h0001, 16'h0000);
      set_rect(1, 0, 0, 0, 1, 2);
      set_rect(1, 1, 6, 20, 7, 25);
      set_vec(2, "count_zero", 0, 16'h0000, 16'h0000);
      set_rect(2, 0, 0, 0, 1, 2);
      set_rect(2, 1, 6, 20, 7, 25);
      set_vec(3, "full_clip", 1, 16'hFFFF, 16'hFFFF);
      set_rect(3, 0, 0, 0, 200, 255);
      set_vec(4, "straddle_empty", 2, 16'h0300, 16'h0003);
      set_rect(4, 0, 3, 3, 4, 4);
      set_rect(4, 1, 5, 0, 2, 9);
      set_vec(5, "top_oob", 1, 16'h0000, 16'h0000);
      set_rect(5, 0, 8, 0, 9, 3);
      set_vec(6, "left_oob", 1, 16'h0000, 16'h0000);
      set_rect(6, 0, 0, 32, 7, 40);
      set_vec(7, "corner_cell", 1, 16'h0000, 16'h8000);
      set_rect(7, 0, 7, 31, 7, 31);
      set_vec(8, "left_gt_right", 1, 16'h0000, 16'h0000);
      set_rect(8, 0, 0, 10, 7, 5);
      set_vec(9, "overlap_dup", 3, 16'h0C80, 16'h0000);
      set_rect(9, 0, 2, 8, 3, 15);
      set_rect(9, 1, 2, 8, 3, 15);
      set_rect(9, 2, 0, 28, 1, 31);
      set_vec(10, "right_clip", 1, 16'h0000, 16'h0080);
      set_rect(10, 0, 4, 30, 5, 100);

      rst = 1'b1;
      num_hazards = 4'd0;
      fill_table(0, 0, 0, 0);
      step();
      check_output("reset_state", 16'h0000, 16'h0000);

      @(negedge clk);
      rst = 1'b0;
      for (int v = 0; v < NUM_VECS; v++) begin
         @(negedge clk);
         apply_stimulus(v);
         step();
         check_output(vecs[v].name, vecs[v].e1, vecs[v].e2);
      end

      // Reset mid-stream, held across changing inputs, then recovery.
      @(negedge clk);
      apply_stimulus(3);
      step();
      check_output("pre_reset_full", 16'hFFFF, 16'hFFFF);
      @(negedge clk);
      rst = 1'b1;
      step();
      check_output("reset_clears", 16'h0000, 16'h0000);
      @(negedge clk);
      apply_stimulus(0);
      step();
      check_output("reset_held", 16'h0000, 16'h0000);
      @(negedge clk);
      apply_stimulus(3);
      rst = 1'b0;
      step();
      check_output("post_reset", 16'hFFFF, 16'hFFFF);

      // Slot 15 must stay ignored even with num_hazards at its maximum.
      @(negedge clk);
      fill_table(5, 0, 2, 9);
      top[15] = 8'd0; left[15] = 8'd0; bottom[15] = 8'd255; right[15] = 8'd255;
      num_hazards = 4'd15;
      step();
      check_output("slot15_ignored", 16'h0000, 16'h0000);
      @(negedge clk);
      top[14] = 8'd6; left[14] = 8'd20; bottom[14] = 8'd7; right[14] = 8'd25;
      step();
      check_output("slot14_used", 16'h0000, 16'h6000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
